// File: rtl/shared_nand_arbiter.sv
// Four-requester round-robin arbiter sharing one switch-level NAND datapath.
// Optional x/z integrity check on the captured result: define NAND_XCHECK_EN.
module shared_nand_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [3:0]         req_in,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  output logic [3:0]         gnt_out,
  output logic [3:0]         done_out,
  output logic [WIDTH-1:0]   y_out,
  output logic               busy_out,
  output logic               err_out,
  output logic [1:0]         state_dbg_out
);

  // Handshake: a requester raises req_in[i] and holds it (with stable operands
  // up to the grant edge) until done_out[i] pulses; operands are latched at grant.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_win;
  logic [3:0]       r_gnt;
  logic [3:0]       r_done;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_found;

  supply1           w_vdd;
  supply0           w_gnd;
  wire [WIDTH-1:0]  w_cell_y;
  wire [WIDTH-1:0]  w_cell_mid;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      pmos u_pa (w_cell_y[gi], w_vdd, r_a[gi]);
      pmos u_pb (w_cell_y[gi], w_vdd, r_b[gi]);
      nmos u_na (w_cell_mid[gi], w_gnd, r_a[gi]);
      nmos u_nb (w_cell_y[gi], w_cell_mid[gi], r_b[gi]);
    end
  endgenerate

  // Search last+1 .. last+4 (mod 4); the previous winner has lowest priority.
  always_comb begin
    w_win   = r_last;
    w_found = 1'b0;
    w_idx   = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + k[1:0];
      if (!w_found && req_in[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

`ifdef NAND_XCHECK_EN
  logic r_err;
  assign err_out = r_err;
`else
  assign err_out = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_win   <= 2'd0;
      r_gnt   <= 4'b0;
      r_done  <= 4'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
`ifdef NAND_XCHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_in) begin
            r_win   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_a     <= a_in[w_win*WIDTH +: WIDTH];
            r_b     <= b_in[w_win*WIDTH +: WIDTH];
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_y     <= w_cell_y;
          r_done  <= r_gnt;
          r_last  <= r_win;
`ifdef NAND_XCHECK_EN
          r_err   <= $isunknown(w_cell_y);
`endif
          r_state <= RESP;
        end
        RESP: begin
          r_gnt   <= 4'b0;
          r_done  <= 4'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_out       = r_gnt;
  assign done_out      = r_done;
  assign y_out         = r_y;
  assign busy_out      = (r_state != IDLE);
  assign state_dbg_out = r_state;

endmodule

// File: tb/tb_shared_nand_arbiter.sv
// Directed bench for shared_nand_arbiter: expected done/y pushed to a queue,
// popped by an independent monitor on every done_out pulse.
module tb_shared_nand_arbiter;
  localparam int W = 8;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic [3:0]     req_in;
  logic [4*W-1:0] a_in;
  logic [4*W-1:0] b_in;
  logic [3:0]     gnt_out;
  logic [3:0]     done_out;
  logic [W-1:0]   y_out;
  logic           busy_out;
  logic           err_out;
  logic [1:0]     state_dbg_out;

  int n_checks = 0;
  int n_errors = 0;

  // entry = {check_y, done one-hot, y}
  logic [12:0] exp_q[$];

  logic [W-1:0] a_tab[4];
  logic [W-1:0] b_tab[4];
  logic [W-1:0] y_tab[4];

  shared_nand_arbiter #(.WIDTH(W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_in        (req_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .gnt_out       (gnt_out),
    .done_out      (done_out),
    .y_out         (y_out),
    .busy_out      (busy_out),
    .err_out       (err_out),
    .state_dbg_out (state_dbg_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_op(input int idx, input logic [W-1:0] y, input bit chk_y);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    exp_q.push_back({chk_y, oh, y});
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   gnt_out,  32'h0);
    check({tag, "_done"},  done_out, 32'h0);
    check({tag, "_y"},     y_out,    32'h0);
    check({tag, "_busy"},  busy_out, 32'h0);
    check({tag, "_err"},   err_out,  32'h0);
    check({tag, "_state"}, state_dbg_out, 32'h0);
  endtask

  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(posedge clk_in);
      #1;
      if (done_out != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", done_out, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("sb_done", done_out, e[11:8]);
          if (e[12]) check("sb_y", y_out, e[7:0]);
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] oh;
    a_tab = '{8'hF0, 8'hAA, 8'h0F, 8'hFF};
    b_tab = '{8'hCC, 8'h55, 8'h3C, 8'h81};
    y_tab = '{8'h3F, 8'hFF, 8'hF3, 8'h7E};
    rst_in = 1'b1;
    req_in = 4'b0;
    a_in   = '0;
    b_in   = '0;
    #1;
    check_reset_outputs("rst0");
    tick();
    tick();
    rst_in = 1'b0;

    // single request, latency and result
    set_ops(0, 8'hF0, 8'hCC);
    req_in = 4'b0001;
    expect_op(0, 8'h3F, 1'b1);
    tick();
    check("t1_gnt", gnt_out, 32'h1);
    check("t1_busy", busy_out, 32'h1);
    check("t1_done_early", done_out, 32'h0);
    tick();
    check("t1_y", y_out, 32'h3F);
    req_in = 4'b0;
    tick();
    check("t1_idle_busy", busy_out, 32'h0);
    check("t1_idle_gnt", gnt_out, 32'h0);
    check("t1_idle_done", done_out, 32'h0);

    // all four held: round robin 0,1,2,3,0 from reset priority
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, a_tab[i], b_tab[i]);
    req_in = 4'b1111;
    for (int k = 0; k < 5; k++) expect_op(k % 4, y_tab[k % 4], 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      oh = 4'b0001 << (k % 4);
      check("t2_gnt", gnt_out, oh);
      tick();
      tick();
    end
    req_in = 4'b0;
    tick();
    check("t2_idle_busy", busy_out, 32'h0);

    // serve 2, then 0101 must pick 0
    req_in = 4'b0100;
    expect_op(2, 8'hF3, 1'b1);
    tick();
    check("t3_gnt2", gnt_out, 32'h4);
    tick();
    req_in = 4'b0;
    tick();
    req_in = 4'b0101;
    expect_op(0, 8'h3F, 1'b1);
    tick();
    check("t3_gnt0", gnt_out, 32'h1);
    tick();
    req_in = 4'b0;
    tick();

    // operand change and request drop during EVAL
    set_ops(1, 8'h96, 8'h0F);
    req_in = 4'b0010;
    expect_op(1, 8'hF9, 1'b1);
    tick();
    check("t4_gnt", gnt_out, 32'h2);
    set_ops(1, 8'h00, 8'h00);
    req_in = 4'b0;
    tick();
    check("t4_y", y_out, 32'hF9);
    check("t4_done", done_out, 32'h2);
    tick();
    check("t4_busy", busy_out, 32'h0);
    tick();
    check("t4_y_hold", y_out, 32'hF9);

    // asynchronous reset during EVAL aborts the operation
    req_in = 4'b0100;
    tick();
    check("t5_gnt", gnt_out, 32'h4);
    #2;
    rst_in = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    tick();
    rst_in = 1'b0;
    req_in = 4'b0111;
    expect_op(0, 8'h3F, 1'b1);
    tick();
    check("t5_gnt_after_rst", gnt_out, 32'h1);
    tick();
    req_in = 4'b0;
    tick();

    // unknown operand bits and the integrity flag
    set_ops(0, 8'b0000_xxxx, 8'hFF);
    req_in = 4'b0001;
    expect_op(0, 8'h00, 1'b0);
    tick();
    check("t6_gnt", gnt_out, 32'h1);
    tick();
    req_in = 4'b0;
`ifdef NAND_XCHECK_EN
    check("t6_err_resp", err_out, 32'h1);
`else
    check("t6_err_resp", err_out, 32'h0);
`endif
    tick();
`ifdef NAND_XCHECK_EN
    check("t6_err_hold", err_out, 32'h1);
`else
    check("t6_err_hold", err_out, 32'h0);
`endif

    tick();
    tick();
    check("queue_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
